// File: rtl/m_prog_ram_pkg.sv
// rtl/m_prog_ram_pkg.sv - shared widths, depth and FSM encoding for the program RAM
package m_prog_ram_pkg;

    localparam int ADR_W     = 4;
    localparam int DAT_W     = 8;
    localparam int MEM_DEPTH = 2 ** ADR_W;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

endpackage

// File: rtl/m_prog_ram_if.sv
// rtl/m_prog_ram_if.sv - operator/read-port bundle of the program RAM
interface m_prog_ram_if;
    import m_prog_ram_pkg::*;

    logic [DAT_W-1:0] wr_data;
    logic             wr_stb;
    logic             clr_stb;
    logic [ADR_W-1:0] rd_adr;
    logic [DAT_W-1:0] rd_dat;
    logic [ADR_W-1:0] wr_adr;
    logic             full;
    logic             busy;

    modport master (
        output wr_data, wr_stb, clr_stb, rd_adr,
        input  rd_dat, wr_adr, full, busy
    );

    modport slave (
        input  wr_data, wr_stb, clr_stb, rd_adr,
        output rd_dat, wr_adr, full, busy
    );

endinterface

// File: rtl/m_prog_ram_sync_rise.sv
// rtl/m_prog_ram_sync_rise.sv - two-flop synchronizer with rising-edge pulse
module m_sync_rise (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic sync3;

    // Resynchronize the button level and keep one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise = sync2 & ~sync3;

endmodule

// File: rtl/m_prog_ram.sv
// rtl/m_prog_ram.sv - 16x8 button-loaded program RAM with clear sweep
module m_prog_ram
    import m_prog_ram_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    m_prog_ram_if.slave   bus
);

    localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(MEM_DEPTH - 1);
    localparam logic [ADR_W-1:0] ONE_ADR  = ADR_W'(1);

    logic [DAT_W-1:0] mem [MEM_DEPTH];

    state_t           state, state_nxt;
    logic [ADR_W-1:0] clr_idx, clr_idx_nxt;
    logic [ADR_W-1:0] wr_adr, wr_adr_nxt;
    logic             full, full_nxt;

    logic             wr_rise;
    logic             clr_rise;

    logic             mem_we;
    logic [ADR_W-1:0] mem_wa;
    logic [DAT_W-1:0] mem_wd;

    m_sync_rise u_wr_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.wr_stb),
        .rise (wr_rise)
    );

    m_sync_rise u_clr_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.clr_stb),
        .rise (clr_rise)
    );

    // Control registers; reset parks the FSM at the start of a clear sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_CLEAR;
            clr_idx <= '0;
            wr_adr  <= '0;
            full    <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
            wr_adr  <= wr_adr_nxt;
            full    <= full_nxt;
        end
    end

    // Next state and the single memory write port: sweep zeros while clearing,
    // otherwise a clear pulse beats a simultaneous write pulse.
    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        wr_adr_nxt  = wr_adr;
        full_nxt    = full;
        mem_we      = 1'b0;
        mem_wa      = wr_adr;
        mem_wd      = bus.wr_data;
        case (state)
            S_CLEAR: begin
                mem_we      = 1'b1;
                mem_wa      = clr_idx;
                mem_wd      = '0;
                clr_idx_nxt = clr_idx + ONE_ADR;
                if (clr_idx == LAST_ADR) begin
                    state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (clr_rise) begin
                    state_nxt   = S_CLEAR;
                    clr_idx_nxt = '0;
                    wr_adr_nxt  = '0;
                    full_nxt    = 1'b0;
                end else if (wr_rise && !full) begin
                    mem_we     = 1'b1;
                    wr_adr_nxt = wr_adr + ONE_ADR;
                    if (wr_adr == LAST_ADR) begin
                        full_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = S_CLEAR;
            end
        endcase
    end

    // Memory array has no reset of its own; the clear sweep zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    assign bus.rd_dat = mem[bus.rd_adr];
    assign bus.wr_adr = wr_adr;
    assign bus.full   = full;
    assign bus.busy   = (state == S_CLEAR);

endmodule

// File: tb/tb_m_prog_ram.sv
// tb/tb_m_prog_ram.sv - directed self-checking bench for m_prog_ram
module tb_m_prog_ram;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    m_prog_ram_if bus ();

    m_prog_ram dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_wr(input logic [7:0] d);
        bus.wr_data = d;
        bus.wr_stb  = 1'b1;
        step(4);
        bus.wr_stb  = 1'b0;
        step(4);
    endtask

    task automatic do_clear();
        bus.clr_stb = 1'b1;
        step(4);
        bus.clr_stb = 1'b0;
        step(20);
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        step(3);
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_busy got=%b exp=1", bus.busy);
        end
        total++;
        if (bus.wr_adr !== 4'd0 || bus.full !== 1'b0) begin
            bad++;
            $display("FAIL reset_ptr got wr_adr=%0d full=%b exp 0/0", bus.wr_adr, bus.full);
        end
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.busy) break;
            n++;
            step(1);
        end
        total++;
        if (n != 16) begin
            bad++;
            $display("FAIL reset_sweep_len got=%0d exp=16", n);
        end
        for (int i = 0; i < 16; i++) begin
            bus.rd_adr = 4'(i);
            #1;
            total++;
            if (bus.rd_dat !== 8'h00) begin
                bad++;
                $display("FAIL reset_mem[%0d] got=%h exp=00", i, bus.rd_dat);
            end
        end
        total++;
        if (bus.wr_adr !== 4'd0 || bus.full !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_ptr got wr_adr=%0d full=%b exp 0/0", bus.wr_adr, bus.full);
        end
    endtask

    task automatic test_single_write();
        bus.rd_adr  = 4'd0;
        bus.wr_data = 8'h51;
        bus.wr_stb  = 1'b1;
        step(2);
        total++;
        if (bus.rd_dat !== 8'h00) begin
            bad++;
            $display("FAIL single_early got=%h exp=00", bus.rd_dat);
        end
        step(1);
        total++;
        if (bus.rd_dat !== 8'h51) begin
            bad++;
            $display("FAIL single_third_edge got=%h exp=51", bus.rd_dat);
        end
        step(17);
        bus.wr_stb = 1'b0;
        step(4);
        total++;
        if (bus.rd_dat !== 8'h51 || bus.wr_adr !== 4'd1) begin
            bad++;
            $display("FAIL single_once got dat=%h wr_adr=%0d exp 51/1", bus.rd_dat, bus.wr_adr);
        end
        bus.rd_adr = 4'd1;
        #1;
        total++;
        if (bus.rd_dat !== 8'h00) begin
            bad++;
            $display("FAIL single_next got=%h exp=00", bus.rd_dat);
        end
    endtask

    task automatic test_fill_overflow();
        do_clear();
        for (int i = 0; i < 16; i++) begin
            pulse_wr(8'h10 + 8'(i));
        end
        total++;
        if (bus.full !== 1'b1 || bus.wr_adr !== 4'd0) begin
            bad++;
            $display("FAIL fill_flags got full=%b wr_adr=%0d exp 1/0", bus.full, bus.wr_adr);
        end
        for (int i = 0; i < 16; i++) begin
            bus.rd_adr = 4'(i);
            #1;
            total++;
            if (bus.rd_dat !== 8'h10 + 8'(i)) begin
                bad++;
                $display("FAIL fill_mem[%0d] got=%h exp=%h", i, bus.rd_dat, 8'h10 + 8'(i));
            end
        end
        pulse_wr(8'hAA);
        bus.rd_adr = 4'd0;
        #1;
        total++;
        if (bus.rd_dat !== 8'h10 || bus.full !== 1'b1 || bus.wr_adr !== 4'd0) begin
            bad++;
            $display("FAIL overflow got mem0=%h full=%b wr_adr=%0d exp 10/1/0",
                     bus.rd_dat, bus.full, bus.wr_adr);
        end
    endtask

    task automatic test_clear_collision();
        int n;
        do_clear();
        for (int i = 0; i < 5; i++) begin
            pulse_wr(8'h20 + 8'(i));
        end
        bus.rd_adr  = 4'd5;
        bus.wr_data = 8'h77;
        bus.wr_stb  = 1'b1;
        bus.clr_stb = 1'b1;
        step(3);
        total++;
        if (bus.rd_dat !== 8'h00 || bus.wr_adr !== 4'd0) begin
            bad++;
            $display("FAIL collision_write got mem5=%h wr_adr=%0d exp 00/0", bus.rd_dat, bus.wr_adr);
        end
        bus.wr_stb  = 1'b0;
        bus.clr_stb = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.busy) break;
            n++;
            step(1);
        end
        total++;
        if (n != 16) begin
            bad++;
            $display("FAIL collision_sweep_len got=%0d exp=16", n);
        end
        for (int i = 0; i < 16; i++) begin
            bus.rd_adr = 4'(i);
            #1;
            total++;
            if (bus.rd_dat !== 8'h00) begin
                bad++;
                $display("FAIL collision_mem[%0d] got=%h exp=00", i, bus.rd_dat);
            end
        end
        total++;
        if (bus.wr_adr !== 4'd0 || bus.full !== 1'b0) begin
            bad++;
            $display("FAIL collision_ptr got wr_adr=%0d full=%b exp 0/0", bus.wr_adr, bus.full);
        end
    endtask

    task automatic test_write_during_clear();
        pulse_wr(8'h33);
        bus.clr_stb = 1'b1;
        step(5);
        bus.clr_stb = 1'b0;
        bus.wr_data = 8'h99;
        bus.wr_stb  = 1'b1;
        step(3);
        bus.wr_stb  = 1'b0;
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL wdc_busy got=%b exp=1", bus.busy);
        end
        step(30);
        bus.rd_adr = 4'd0;
        #1;
        total++;
        if (bus.rd_dat !== 8'h00 || bus.wr_adr !== 4'd0) begin
            bad++;
            $display("FAIL wdc_discard got mem0=%h wr_adr=%0d exp 00/0", bus.rd_dat, bus.wr_adr);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        int drops;
        drops = 0;
        bus.clr_stb = 1'b1;
        step(4);
        bus.clr_stb = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (!bus.busy) drops++;
            step(1);
        end
        rst = 1'b1;
        step(1);
        if (!bus.busy) drops++;
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.busy) break;
            n++;
            step(1);
        end
        total++;
        if (drops != 0) begin
            bad++;
            $display("FAIL midrst_drop got=%0d exp=0", drops);
        end
        total++;
        if (n != 16) begin
            bad++;
            $display("FAIL midrst_sweep_len got=%0d exp=16", n);
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        bus.wr_data = 8'h00;
        bus.wr_stb  = 1'b0;
        bus.clr_stb = 1'b0;
        bus.rd_adr  = 4'd0;
        test_reset();
        test_single_write();
        test_fill_overflow();
        test_clear_collision();
        test_write_during_clear();
        test_reset_mid_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/m_prog_ram.md
Name: m_prog_ram

Overview:
- Writable 16x8 program memory. It is the write-side counterpart of the team's combinational 4-bit-address / 8-bit-data ROM.
- An operator enters bytes on switches (wr_data) and commits them with a debounced push-button (wr_stb). Entries go into consecutive addresses.
- A second debounced button (clr_stb) zero-fills the whole memory.
- The read port has the same adr/dat shape as the ROM, so downstream logic can use either block.

Parameters:
- ADR_W, 4, address width; depth = 2**ADR_W.
- DAT_W, 8, data word width.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- wr_data  input  DAT_W  switch data; quasi-static, not synchronized; must be stable at the commit edge.
- wr_stb  input  1  debounced write button level; asynchronous to clk.
- clr_stb  input  1  debounced clear button level; asynchronous to clk.
- rd_adr  input  ADR_W  read address.
- rd_dat  output  DAT_W  combinational read: mem[rd_adr].
- wr_adr  output  ADR_W  next write pointer.
- full  output  1  all 2**ADR_W locations written since the last clear.
- busy  output  1  clear sweep in progress.

Behaviour:
- One clock (clk). Reset is synchronous, active-high (rst).
- Synchronizers and edge detection:
  - wr_stb and clr_stb each pass through a 2-flop synchronizer, then a third flop for edge detection.
  - Rise pulse = sync2 & ~sync3.
  - A write commits on the 3rd rising clk edge at which wr_stb is sampled high, counting the first sampling edge as 1. Clear starts with the same latency from clr_stb.
- Level-held buttons produce exactly one pulse. A new pulse needs a 0 sample in between.
- FSM states: CLEAR, IDLE.
- CLEAR state:
  - Sweep index clr_idx runs 0..15, one location per cycle; mem[clr_idx] <= 0.
  - busy = 1.
  - Write pulses and clear pulses are ignored (discarded, not queued).
  - After writing location 15 -> IDLE; busy = 0 on the following cycle.
  - A sweep lasts exactly 16 cycles.
- IDLE state:
  - Clear pulse -> CLEAR with clr_idx = 0, wr_adr = 0, full = 0.
  - Otherwise, write pulse with full = 0: mem[wr_adr] <= wr_data and wr_adr <= wr_adr + 1 (mod 16). If the old wr_adr was 15, full <= 1.
  - Write pulse with full = 1: ignored; memory and wr_adr unchanged.
- Simultaneous clear and write pulses in the same cycle: clear wins, no write.
- Reset:
  - While rst = 1: state = CLEAR, clr_idx = 0, wr_adr = 0, full = 0, busy = 1, all synchronizer/edge flops = 0.
  - After rst falls: full 16-cycle sweep, then IDLE. busy = 1 from the first rst cycle through the last sweep cycle.
  - rst mid-sweep restarts the sweep from index 0.
  - Memory contents are not directly reset; the sweep zeroes them.
- Read port:
  - Asynchronous, no latency.
  - A write committed at edge N is visible on rd_dat immediately after edge N.
  - During CLEAR, rd_dat may show pre-clear data for locations not yet swept.
- wr_adr wraps 15 -> 0 on the 16th write. full disambiguates the wrapped pointer from an empty memory.

Decomposition:
- Shared package:
  - ADR_W = 4, DAT_W = 8 (shared with the ROM).
  - FSM state encoding: S_CLEAR = 1'b0, S_IDLE = 1'b1.
  - MEM_DEPTH = 16.
- One natural sub-module: m_sync_rise, a 2-flop synchronizer plus rising-edge detector.
  - Synchronous reset.
  - Instantiated twice, for wr_stb and clr_stb.

Test Plan:
- Reset then idle:
  - rst high 3 cycles, then low -> busy = 1 for exactly 16 cycles after release, then 0.
  - rd_adr sweep 0..15 returns 8'h00 everywhere; wr_adr = 0, full = 0.
- Single write:
  - After idle, wr_data = 8'h51, wr_stb high 20 cycles.
  - Exactly one write, on the 3rd sampling edge -> rd_adr = 0 gives 8'h51, wr_adr = 1, rd_adr = 1 still 8'h00.
- Fill and overflow:
  - 16 write pulses with data 8'h10..8'h1F -> full = 1, wr_adr = 0, mem[i] = 8'h10 + i.
  - 17th pulse with 8'hAA -> ignored; mem[0] = 8'h10, full stays 1.
- Clear collision:
  - After 5 writes, clr_stb and wr_stb rise in the same cycle -> no write to mem[5].
  - busy high 16 cycles; afterwards all locations 8'h00, wr_adr = 0, full = 0.
- Write during clear: wr_stb pulse at sweep index 4 -> discarded; after sweep mem[0] = 8'h00, wr_adr = 0.
- Reset mid-sweep: rst pulsed 1 cycle at sweep index 7 -> busy never drops; it falls exactly 16 cycles after rst release.
